// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-bundle signals of the instruction decode stage.
// slave: the decode stage itself; master: the instruction source and bundle consumer.
interface instr_decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             instr_valid_i;
  logic             instr_ready_o;
  logic [31:0]      instr_i;
  logic             dec_valid_o;
  logic             dec_ready_i;
  logic [6:0]       opcode_o;
  logic [2:0]       imm_src_o;
  logic [XLEN-1:0]  imm_o;
  logic [4:0]       rd_o;
  logic [4:0]       rs1_o;
  logic [4:0]       rs2_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  modport slave (
    input  instr_valid_i, instr_i, dec_ready_i,
    output instr_ready_o, dec_valid_o, opcode_o, imm_src_o, imm_o,
           rd_o, rs1_o, rs2_o, illegal_o, illegal_cnt_o
  );

  modport master (
    output instr_valid_i, instr_i, dec_ready_i,
    input  instr_ready_o, dec_valid_o, opcode_o, imm_src_o, imm_o,
           rd_o, rs1_o, rs2_o, illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered RISC-V decode stage: immediate select/extension, register fields,
// illegal-opcode flag, two-entry skid buffer and a saturating illegal counter.
// Optional macro DECODE_SYSTEM_EN: treat SYSTEM opcode as legal (CSR address as imm).
module instr_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  instr_decode_stage_if.slave  bus
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned SRC_W = 3;

  localparam logic [OPC_W-1:0] OP_L      = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_S      = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_B      = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
`ifdef DECODE_SYSTEM_EN
  localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;
`endif

  localparam logic [SRC_W-1:0] EXT_I = 3'd0;
  localparam logic [SRC_W-1:0] EXT_S = 3'd1;
  localparam logic [SRC_W-1:0] EXT_B = 3'd2;
  localparam logic [SRC_W-1:0] EXT_J = 3'd3;
  localparam logic [SRC_W-1:0] EXT_U = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [SRC_W-1:0] imm_src;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             illegal;
  } dec_t;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           state_q;
  dec_t             dec_c;
  dec_t             out_q;
  dec_t             skid_q;
  logic             out_valid_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c;
  logic             out_xfer_c;
  logic [31:0]      instr_c;

  assign instr_c    = bus.instr_i;
  assign accept_c   = bus.instr_valid_i & ready_q;
  assign out_xfer_c = out_valid_q & bus.dec_ready_i;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    dec_c         = '0;
    dec_c.opcode  = instr_c[6:0];
    dec_c.rd      = instr_c[11:7];
    dec_c.rs1     = instr_c[19:15];
    dec_c.rs2     = instr_c[24:20];
    dec_c.imm_src = EXT_I;
    case (instr_c[6:0])
      OP_L, OP_I, OP_JALR: dec_c.imm = XLEN'($signed(instr_c[31:20]));
      OP_S: begin
        dec_c.imm_src = EXT_S;
        dec_c.imm     = XLEN'($signed({instr_c[31:25], instr_c[11:7]}));
      end
      OP_B: begin
        dec_c.imm_src = EXT_B;
        dec_c.imm     = XLEN'($signed({instr_c[31], instr_c[7], instr_c[30:25],
                                        instr_c[11:8], 1'b0}));
      end
      OP_JAL: begin
        dec_c.imm_src = EXT_J;
        dec_c.imm     = XLEN'($signed({instr_c[31], instr_c[19:12], instr_c[20],
                                        instr_c[30:21], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec_c.imm_src = EXT_U;
        dec_c.imm     = XLEN'($signed({instr_c[31:12], 12'b0}));
      end
      OP_R: dec_c.imm = '0;
`ifdef DECODE_SYSTEM_EN
      OP_SYSTEM: dec_c.imm = XLEN'(instr_c[31:20]);
`endif
      default: dec_c.illegal = 1'b1;
    endcase
  end

  // Skid-buffer FSM, output/skid registers and saturating illegal counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_EMPTY;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept_c && dec_c.illegal && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_EMPTY: begin
          if (accept_c) begin
            if (out_valid_q && !bus.dec_ready_i) begin
              skid_q  <= dec_c;
              state_q <= S_FULL;
              ready_q <= 1'b0;
            end else begin
              out_q       <= dec_c;
              out_valid_q <= 1'b1;
            end
          end else if (out_xfer_c) begin
            out_valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (out_xfer_c) begin
            out_q   <= skid_q;
            state_q <= S_EMPTY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.instr_ready_o = ready_q;
  assign bus.dec_valid_o   = out_valid_q;
  assign bus.opcode_o      = out_q.opcode;
  assign bus.imm_src_o     = out_q.imm_src;
  assign bus.imm_o         = out_q.imm;
  assign bus.rd_o          = out_q.rd;
  assign bus.rs1_o         = out_q.rs1;
  assign bus.rs2_o         = out_q.rs2;
  assign bus.illegal_o     = out_q.illegal;
  assign bus.illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: a reference decode model feeds a
// queue on every input transfer; the monitor pops and compares on every output
// transfer. A second instance with a 2-bit counter exercises saturation.
module tb_instr_decode_stage;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_decode_stage_if #(.XLEN(XLEN), .CNT_W(16)) bus ();
  instr_decode_stage_if #(.XLEN(XLEN), .CNT_W(2))  bus2 ();

  instr_decode_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  instr_decode_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int pop_cnt = 0;
  logic [15:0] exp_cnt = '0;
  logic [63:0] sb[$];
  logic [31:0] seen_imm[$];
  logic        seen_ill[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference decode, packed as {pad, opcode, imm_src, imm, rd, rs1, rs2, illegal}.
  function automatic logic [63:0] model(input logic [31:0] ins);
    logic [31:0] imm;
    logic [2:0]  src;
    logic        ill;
    src = 3'd0; imm = '0; ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: imm = {{20{ins[31]}}, ins[31:20]};
      7'h23: begin src = 3'd1; imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'h63: begin src = 3'd2; imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h6F: begin src = 3'd3; imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h37, 7'h17: begin src = 3'd4; imm = {ins[31:12], 12'b0}; end
      7'h33: imm = '0;
`ifdef DECODE_SYSTEM_EN
      7'h73: imm = {20'b0, ins[31:20]};
`endif
      default: ill = 1'b1;
    endcase
    return {6'b0, ins[6:0], src, imm, ins[11:7], ins[19:15], ins[24:20], ill};
  endfunction

  function automatic logic [63:0] observed();
    return {6'b0, bus.opcode_o, bus.imm_src_o, bus.imm_o,
            bus.rd_o, bus.rs1_o, bus.rs2_o, bus.illegal_o};
  endfunction

  // Monitor: counter check, then pop on output transfer, then push on input transfer.
  always @(negedge clk) begin
    if (!rst) begin
      logic [63:0] e;
      check("illegal_cnt", 64'(bus.illegal_cnt_o), 64'(exp_cnt));
      if (bus.dec_valid_o && bus.dec_ready_i) begin
        if (sb.size() == 0) begin
          check("spurious_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("bundle", observed(), e);
          seen_imm.push_back(bus.imm_o);
          seen_ill.push_back(bus.illegal_o);
          pop_cnt++;
        end
      end
      if (bus.instr_valid_i && bus.instr_ready_o) begin
        e = model(bus.instr_i);
        sb.push_back(e);
        if (e[0] && exp_cnt != 16'hFFFF) exp_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction, hold it until taken, return 1 ns after the accepting edge.
  task automatic send(input logic [31:0] ins);
    int t;
    t = 0;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = ins;
    @(negedge clk);
    while (!bus.instr_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.instr_ready_o) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    sb.delete();
    exp_cnt = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int p0;
    logic [63:0] snap;
    rst = 1'b1;
    bus.instr_valid_i  = 1'b0;
    bus.instr_i        = '0;
    bus.dec_ready_i    = 1'b1;
    bus2.instr_valid_i = 1'b0;
    bus2.instr_i       = '0;
    bus2.dec_ready_i   = 1'b1;
    step();
    check("rst_dec_valid", 64'(bus.dec_valid_o), 64'd0);
    check("rst_ready", 64'(bus.instr_ready_o), 64'd1);
    check("rst_cnt", 64'(bus.illegal_cnt_o), 64'd0);
    check("rst_bundle", observed(), 64'd0);
    step();
    rst = 1'b0;

    // Single I-type, one-cycle latency.
    send(32'hFFF00093);
    @(negedge clk); #1;
    check("t1_valid", 64'(bus.dec_valid_o), 64'd1);
    check("t1_src", 64'(bus.imm_src_o), 64'd0);
    check("t1_imm", 64'(bus.imm_o), 64'h0000_0000_FFFF_FFFF);
    check("t1_rd", 64'(bus.rd_o), 64'd1);
    check("t1_illegal", 64'(bus.illegal_o), 64'd0);
    step();

    // Back-to-back S, B, U with no bubbles.
    seen_imm.delete();
    c0 = cyc;
    send(32'h0020A423);
    send(32'hFE000EE3);
    send(32'h123452B7);
    @(negedge clk); #1;
    check("b2b_cycles", 64'(cyc - c0), 64'd3);
    check("b2b_count", 64'(seen_imm.size()), 64'd3);
    if (seen_imm.size() == 3) begin
      check("b2b_imm_s", 64'(seen_imm[0]), 64'h0000_0008);
      check("b2b_imm_b", 64'(seen_imm[1]), 64'hFFFF_FFFC);
      check("b2b_imm_u", 64'(seen_imm[2]), 64'h1234_5000);
    end
    step();

    // Stall: two accepted, third blocked, then drained in order.
    bus.dec_ready_i = 1'b0;
    p0 = pop_cnt;
    send(32'h00500113);
    send(32'h00A00193);
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = 32'h0000A203;
    @(negedge clk); #1;
    check("full_ready", 64'(bus.instr_ready_o), 64'd0);
    check("full_valid", 64'(bus.dec_valid_o), 64'd1);
    check("full_head", observed(), model(32'h00500113));
    snap = observed();
    step();
    @(negedge clk); #1;
    check("full_ready_hold", 64'(bus.instr_ready_o), 64'd0);
    check("stall_stable", observed(), snap);
    step();
    bus.dec_ready_i = 1'b1;
    begin
      int t;
      t = 0;
      while (!bus.instr_ready_o && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("drain_ready", 64'(bus.instr_ready_o), 64'd1);
    end
    step();
    bus.instr_valid_i = 1'b0;
    repeat (4) step();
    check("drain_count", 64'(pop_cnt - p0), 64'd3);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Illegal flag and counter.
    do_reset();
    seen_ill.delete();
    send(32'h0000007F);
    send(32'h0000007F);
    send(32'h00000033);
    repeat (3) step();
    check("ill_seen", 64'(seen_ill.size()), 64'd3);
    if (seen_ill.size() == 3) begin
      check("ill_0", 64'(seen_ill[0]), 64'd1);
      check("ill_1", 64'(seen_ill[1]), 64'd1);
      check("ill_2", 64'(seen_ill[2]), 64'd0);
    end
    check("ill_cnt2", 64'(bus.illegal_cnt_o), 64'd2);

    // SYSTEM opcode.
    send(32'h30002573);
    @(negedge clk); #1;
`ifdef DECODE_SYSTEM_EN
    check("sys_illegal", 64'(bus.illegal_o), 64'd0);
    check("sys_imm", 64'(bus.imm_o), 64'h0000_0300);
`else
    check("sys_illegal", 64'(bus.illegal_o), 64'd1);
    step();
    check("sys_cnt", 64'(bus.illegal_cnt_o), 64'd3);
`endif
    step();

    // Reset while the skid entry is occupied.
    bus.dec_ready_i = 1'b0;
    send(32'h00100093);
    send(32'h00200093);
    @(negedge clk); #1;
    check("pre_rst_ready", 64'(bus.instr_ready_o), 64'd0);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.dec_valid_o), 64'd0);
    check("mid_rst_ready", 64'(bus.instr_ready_o), 64'd1);
    check("mid_rst_cnt", 64'(bus.illegal_cnt_o), 64'd0);
    sb.delete();
    exp_cnt = '0;
    bus.dec_ready_i = 1'b1;
    step();
    rst = 1'b0;
    send(32'h02A00513);
    @(negedge clk); #1;
    check("post_rst_valid", 64'(bus.dec_valid_o), 64'd1);
    check("post_rst_imm", 64'(bus.imm_o), 64'd42);
    check("post_rst_rd", 64'(bus.rd_o), 64'd10);
    step();

    // Saturation on the 2-bit counter instance.
    bus2.instr_i       = 32'h0000007F;
    bus2.instr_valid_i = 1'b1;
    repeat (2) step();
    check("sat_cnt2", 64'(bus2.illegal_cnt_o), 64'd2);
    repeat (3) step();
    bus2.instr_valid_i = 1'b0;
    check("sat_cnt_hold", 64'(bus2.illegal_cnt_o), 64'd3);
    step();
    check("sat_cnt_final", 64'(bus2.illegal_cnt_o), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
